// File: rtl/comm_pkg.sv
// Shared definitions for the transmit-side serializer path.
package comm_pkg;

   // Serializer FSM states: idle between bursts, active while bits stream out.
   typedef enum logic {
      SER_IDLE   = 1'b0,
      SER_ACTIVE = 1'b1
   } ser_state_t;

   // Default parallel word width.
   localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/frame_serializer_if.sv
// Parallel word input channel of the frame serializer.
//
// Handshake: the source (master) drives in_data and in_valid; the serializer
// (slave) drives in_ready. A word transfers on a rising clk edge where
// in_valid and in_ready are both high. in_ready does not depend on in_valid,
// and the source must hold in_data stable while in_valid is high and the
// word has not yet transferred.
interface frame_serializer_if
   import comm_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) ();

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/frame_serializer.sv
// Parallel-to-serial converter: one-word holding buffer, shift register and
// a two-state burst FSM. Once a burst starts the stream never gaps; a missing
// word at a boundary is replaced by a fill word and flagged as underrun.
module frame_serializer
   import comm_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit FILL_BIT  = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tx_en,
   frame_serializer_if.slave   in_if,
   output logic                ser_bit,
   output logic                ser_valid,
   output logic                word_start,
   output logic                serializer_start,
   output logic                underrun,
   input  logic                clr_underrun,
   output ser_state_t          state_dbg
);

   localparam int                CNT_W     = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] FILL_WORD = {DATA_W{FILL_BIT}};

   ser_state_t        state;
   logic              hold_full;
   logic [DATA_W-1:0] hold_word;
   logic [DATA_W-1:0] shift_reg;
   logic [CNT_W-1:0]  bit_cnt;

   // Advance the shift register by one bit toward the transmit end.
   function automatic logic [DATA_W-1:0] shift_once(input logic [DATA_W-1:0] v);
      if (MSB_FIRST) shift_once = {v[DATA_W-2:0], 1'b0};
      else           shift_once = {1'b0, v[DATA_W-1:1]};
   endfunction

   // Transmit end of the shift register; cleared whenever the burst ends.
   assign ser_bit        = MSB_FIRST ? shift_reg[DATA_W-1] : shift_reg[0];
   assign in_if.in_ready = ~hold_full;
   assign state_dbg      = state;

   // Holding buffer, shift register, bit counter, burst FSM and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= SER_IDLE;
         hold_full        <= 1'b0;
         hold_word        <= '0;
         shift_reg        <= '0;
         bit_cnt          <= '0;
         ser_valid        <= 1'b0;
         word_start       <= 1'b0;
         serializer_start <= 1'b0;
         underrun         <= 1'b0;
      end else begin
         // Clear first so that a fill insertion on the same edge wins.
         if (clr_underrun) underrun <= 1'b0;

         // Accept only into an empty buffer; a load only drains a full one,
         // so the two never target the same edge.
         if (in_if.in_valid && !hold_full) begin
            hold_word <= in_if.in_data;
            hold_full <= 1'b1;
         end

         case (state)
            SER_IDLE: begin
               // A burst starts only with a real word in hand; never with fill.
               if (tx_en && hold_full) begin
                  state            <= SER_ACTIVE;
                  shift_reg        <= hold_word;
                  hold_full        <= 1'b0;
                  bit_cnt          <= '0;
                  ser_valid        <= 1'b1;
                  serializer_start <= 1'b1;
                  word_start       <= 1'b1;
               end
            end

            SER_ACTIVE: begin
               if (bit_cnt != LAST_BIT) begin
                  // Mid-word: tx_en is ignored, the word always completes.
                  shift_reg  <= shift_once(shift_reg);
                  bit_cnt    <= bit_cnt + 1'b1;
                  word_start <= 1'b0;
               end else if (!tx_en) begin
                  // Burst ends on a word boundary; any held word stays put.
                  state            <= SER_IDLE;
                  shift_reg        <= '0;
                  bit_cnt          <= '0;
                  ser_valid        <= 1'b0;
                  serializer_start <= 1'b0;
                  word_start       <= 1'b0;
               end else if (hold_full) begin
                  // Seamless reload from the holding buffer.
                  shift_reg  <= hold_word;
                  hold_full  <= 1'b0;
                  bit_cnt    <= '0;
                  word_start <= 1'b1;
               end else begin
                  // Source fell behind: keep the stream gap-free with fill.
                  shift_reg  <= FILL_WORD;
                  bit_cnt    <= '0;
                  word_start <= 1'b1;
                  underrun   <= 1'b1;
               end
            end

            default: state <= SER_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: two instances (MSB-first and LSB-first) driven
// with identical stimulus and checked against a word-level stream model.
module tb_frame_serializer;
   import comm_pkg::*;

   localparam int W = 8;
   localparam logic [W-1:0] FILL_W = '0;

   logic clk;
   logic reset;
   logic tx_en;
   logic clr_underrun;

   logic       ser_bit_o   [2];
   logic       ser_valid_o [2];
   logic       word_start_o[2];
   logic       ss_o        [2];
   logic       under_o     [2];
   ser_state_t state_o     [2];

   int total;
   int bad;

   logic [W-1:0] exp_q[$];
   bit           fill_q[$];

   frame_serializer_if #(.DATA_W(W)) si0 ();
   frame_serializer_if #(.DATA_W(W)) si1 ();

   frame_serializer #(.DATA_W(W), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_msb (
      .clk              (clk),
      .reset            (reset),
      .tx_en            (tx_en),
      .in_if            (si0.slave),
      .ser_bit          (ser_bit_o[0]),
      .ser_valid        (ser_valid_o[0]),
      .word_start       (word_start_o[0]),
      .serializer_start (ss_o[0]),
      .underrun         (under_o[0]),
      .clr_underrun     (clr_underrun),
      .state_dbg        (state_o[0])
   );

   frame_serializer #(.DATA_W(W), .MSB_FIRST(1'b0), .FILL_BIT(1'b0)) dut_lsb (
      .clk              (clk),
      .reset            (reset),
      .tx_en            (tx_en),
      .in_if            (si1.slave),
      .ser_bit          (ser_bit_o[1]),
      .ser_valid        (ser_valid_o[1]),
      .word_start       (word_start_o[1]),
      .serializer_start (ss_o[1]),
      .underrun         (under_o[1]),
      .clr_underrun     (clr_underrun),
      .state_dbg        (state_o[1])
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 0) ? si0.in_ready : si1.in_ready;
   endfunction

   task automatic drive_in(input logic v, input logic [W-1:0] data);
      si0.in_valid = v;
      si0.in_data  = data;
      si1.in_valid = v;
      si1.in_data  = data;
   endtask

   // Quiet-output check, used between bursts and during/after reset.
   task automatic check_idle(input string tag, input logic exp_ready, input logic exp_under);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s_bit_d%0d", tag, d),   32'(ser_bit_o[d]),    32'(1'b0));
         chk($sformatf("%s_valid_d%0d", tag, d), 32'(ser_valid_o[d]),  32'(1'b0));
         chk($sformatf("%s_ws_d%0d", tag, d),    32'(word_start_o[d]), 32'(1'b0));
         chk($sformatf("%s_ss_d%0d", tag, d),    32'(ss_o[d]),         32'(1'b0));
         chk($sformatf("%s_under_d%0d", tag, d), 32'(under_o[d]),      32'(exp_under));
         chk($sformatf("%s_ready_d%0d", tag, d), 32'(rdy(d)),          32'(exp_ready));
         chk($sformatf("%s_state_d%0d", tag, d), 32'(state_o[d]),      32'(SER_IDLE));
      end
   endtask

   // Hand over the first word of a burst with tx_en raised; the load follows
   // one edge after the accept.
   task automatic load_first(input logic [W-1:0] w);
      @(negedge clk);
      drive_in(1'b1, w);
      tx_en = 1'b1;
      @(negedge clk);
      drive_in(1'b0, '0);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("load_ready_d%0d", d), 32'(rdy(d)),         32'(1'b0));
         chk($sformatf("load_valid_d%0d", d), 32'(ser_valid_o[d]), 32'(1'b0));
      end
   endtask

   // Check one transmitted word slot bit by bit. Optionally offer the next
   // word at bit supply_at and drop tx_en at bit drop_at (-1 = never).
   task automatic check_slot(input logic [W-1:0] w, input int supply_at,
                             input logic [W-1:0] next_w, input int drop_at,
                             input logic exp_under, input int n_bits, input string tag);
      logic eb;
      logic er;
      for (int b = 0; b < n_bits; b++) begin
         @(negedge clk);
         er = (supply_at < 0) || (b <= supply_at);
         for (int d = 0; d < 2; d++) begin
            eb = (d == 0) ? w[W-1-b] : w[b];
            chk($sformatf("%s_b%0d_bit_d%0d", tag, b, d),   32'(ser_bit_o[d]),    32'(eb));
            chk($sformatf("%s_b%0d_valid_d%0d", tag, b, d), 32'(ser_valid_o[d]),  32'(1'b1));
            chk($sformatf("%s_b%0d_ss_d%0d", tag, b, d),    32'(ss_o[d]),         32'(1'b1));
            chk($sformatf("%s_b%0d_ws_d%0d", tag, b, d),    32'(word_start_o[d]), 32'(b == 0));
            chk($sformatf("%s_b%0d_ready_d%0d", tag, b, d), 32'(rdy(d)),          32'(er));
            chk($sformatf("%s_b%0d_under_d%0d", tag, b, d), 32'(under_o[d]),      32'(exp_under));
         end
         if (b == supply_at) drive_in(1'b1, next_w);
         else                drive_in(1'b0, '0);
         if (b == drop_at) tx_en = 1'b0;
      end
   endtask

   initial begin
      logic [W-1:0] w;
      logic [W-1:0] nw;
      bit           is_fill;
      logic         under_exp;
      int           n_slots;

      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      tx_en        = 1'b0;
      clr_underrun = 1'b0;
      drive_in(1'b0, '0);

      // Reset state
      repeat (2) @(negedge clk);
      check_idle("reset", 1'b1, 1'b0);
      reset = 1'b0;

      // Single word 0xA5, burst ends at the first boundary
      load_first(8'hA5);
      check_slot(8'hA5, -1, '0, 0, 1'b0, W, "single");
      @(negedge clk);
      check_idle("single_end", 1'b1, 1'b0);

      // Single word 0x01 (LSB instance sends 1 first)
      load_first(8'h01);
      check_slot(8'h01, -1, '0, 0, 1'b0, W, "one");
      @(negedge clk);
      check_idle("one_end", 1'b1, 1'b0);

      // Back-to-back 0x3C then 0xFF
      load_first(8'h3C);
      check_slot(8'h3C, 2, 8'hFF, -1, 1'b0, W, "b2b0");
      check_slot(8'hFF, -1, '0, 0, 1'b0, W, "b2b1");
      @(negedge clk);
      check_idle("b2b_end", 1'b1, 1'b0);

      // Underrun: 0x81 then fill, then clear the sticky flag
      load_first(8'h81);
      check_slot(8'h81, -1, '0, -1, 1'b0, W, "urun0");
      check_slot(FILL_W, -1, '0, 0, 1'b1, W, "urun_fill");
      @(negedge clk);
      check_idle("urun_end", 1'b1, 1'b1);
      clr_underrun = 1'b1;
      @(negedge clk);
      clr_underrun = 1'b0;
      check_idle("urun_clr", 1'b1, 1'b0);

      // Mid-word stop at bit 3 of 0xF0 with 0x5A already held
      load_first(8'hF0);
      check_slot(8'hF0, 1, 8'h5A, 3, 1'b0, W, "stop");
      @(negedge clk);
      check_idle("stop_end", 1'b0, 1'b0);
      @(negedge clk);
      check_idle("stop_hold", 1'b0, 1'b0);
      tx_en = 1'b1;
      check_slot(8'h5A, -1, '0, 0, 1'b0, W, "held");
      @(negedge clk);
      check_idle("held_end", 1'b1, 1'b0);

      // Async reset at bit 4, with a word sitting in the holding buffer
      load_first(8'hC3);
      check_slot(8'hC3, 1, 8'h77, -1, 1'b0, 5, "arst");
      #2 reset = 1'b1;
      #1 check_idle("arst_now", 1'b1, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      tx_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_idle($sformatf("empty_idle%0d", i), 1'b1, 1'b0);
      end
      tx_en = 1'b0;

      // Randomized burst: random words, random supply offsets, random gaps
      n_slots   = 16;
      under_exp = 1'b0;
      w = W'($urandom);
      exp_q.push_back(w);
      fill_q.push_back(1'b0);
      load_first(w);
      for (int j = 0; j < n_slots; j++) begin
         w       = exp_q.pop_front();
         is_fill = fill_q.pop_front();
         if (is_fill) under_exp = 1'b1;
         if (j == n_slots - 1) begin
            check_slot(w, -1, '0, $urandom_range(0, W - 1), under_exp, W,
                       $sformatf("rnd%0d", j));
         end else if ($urandom_range(0, 3) == 0) begin
            exp_q.push_back(FILL_W);
            fill_q.push_back(1'b1);
            check_slot(w, -1, '0, -1, under_exp, W, $sformatf("rnd%0d", j));
         end else begin
            nw = W'($urandom);
            exp_q.push_back(nw);
            fill_q.push_back(1'b0);
            check_slot(w, $urandom_range(0, W - 2), nw, -1, under_exp, W,
                       $sformatf("rnd%0d", j));
         end
      end
      @(negedge clk);
      check_idle("rnd_end", 1'b1, under_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
